// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the Riscv151 data-memory arbiter.
// Requester 0 is the CPU load/store path and requester 1 is the UART loader/debug port.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshake and memory port signals for the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters and memory.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*STRB_WIDTH-1:0] req_wstrb;
  logic [1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    mem_en;
  logic [STRB_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_din;
  logic [DATA_WIDTH-1:0]   mem_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_dout,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_dout,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; the registered last grant lives in the parent.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  always_comb begin
    grant     = REQ_CPU;
    any_valid = |req_valid;
    case (req_valid)
      2'b01:   grant = REQ_CPU;
      2'b10:   grant = REQ_LDR;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous-read data memory between the CPU and the loader,
// one outstanding transaction at a time with round-robin fairness.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(MEM_LATENCY + 1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  is_write_q, is_write_d;
  logic [CNT_WIDTH-1:0]  lat_cnt_q, lat_cnt_d;

  logic                  grant;
  logic                  any_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_we;

  logic [1:0]            req_ready;
  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  mem_en;
  logic [STRB_WIDTH-1:0] mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  rr_arbiter2 u_rr (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign sel_addr  = grant ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : bus.req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = grant ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
  assign sel_wstrb = grant ? bus.req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : bus.req_wstrb[STRB_WIDTH-1:0];
  assign sel_we    = bus.req_we[grant];

  // Outputs are held at zero while rst is high so an abandoned WAIT never pulses resp_valid.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    lat_cnt_d    = lat_cnt_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_rdata   = '0;
    mem_en       = 1'b0;
    mem_we       = '0;
    mem_addr     = '0;
    mem_din      = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            req_ready    = onehot2(grant);
            mem_en       = 1'b1;
            mem_we       = sel_we ? sel_wstrb : '0;
            mem_addr     = sel_addr;
            mem_din      = sel_wdata;
            state_d      = ST_WAIT;
            owner_d      = grant;
            last_grant_d = grant;
            is_write_d   = sel_we;
            lat_cnt_d    = CNT_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == CNT_WIDTH'(MEM_LATENCY)) begin
            resp_valid = onehot2(owner_q);
            resp_rdata = is_write_q ? '0 : bus.mem_dout;
            state_d    = ST_IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_din    = mem_din;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a latency-1 instance and a latency-3 instance,
// each backed by a small behavioural synchronous-read memory.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic preload;
  int   checks;
  int   failures;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe3_a, pipe3_b;

  dmem_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) b1 ();
  dmem_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) b3 ();

  dmem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .MEM_LATENCY(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  dmem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .MEM_LATENCY(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Latency-1 memory: registered read, byte-enabled write.
  always @(posedge clk) begin
    if (preload) begin
      mem1[8'h10] <= 32'hDEADBEEF;
      mem1[8'h20] <= 32'hFFFFFFFF;
      mem1[8'h30] <= 32'hA5A5A5A5;
      mem1[8'h40] <= 32'h11112222;
    end else if (b1.mem_en) begin
      for (int i = 0; i < 4; i++)
        if (b1.mem_we[i]) mem1[b1.mem_addr[7:0]][8*i +: 8] <= b1.mem_din[8*i +: 8];
      b1.mem_dout <= mem1[b1.mem_addr[7:0]];
    end
  end

  // Latency-3 memory: the read word walks through two extra register stages.
  always @(posedge clk) begin
    if (preload) begin
      mem3[8'h10] <= 32'hCAFEF00D;
      mem3[8'h40] <= 32'h0BADC0DE;
    end else if (b3.mem_en) begin
      pipe3_a <= mem3[b3.mem_addr[7:0]];
    end
    pipe3_b     <= pipe3_a;
    b3.mem_dout <= pipe3_b;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] we,
                                input logic [13:0] a0, input logic [13:0] a1,
                                input logic [31:0] wd1, input logic [3:0] ws1);
    b1.req_valid = valid;
    b1.req_we    = we;
    b1.req_addr  = {a1, a0};
    b1.req_wdata = {wd1, 32'h0};
    b1.req_wstrb = {ws1, 4'h0};
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_ready;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    preload  = 1'b1;
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    b3.req_valid = 2'b00;
    b3.req_we    = 2'b00;
    b3.req_addr  = '0;
    b3.req_wdata = '0;
    b3.req_wstrb = '0;

    // Reset: requests present but every output stays low.
    cyc();
    apply_stimulus(2'b11, 2'b00, 14'h030, 14'h040, 32'h0, 4'h0);
    @(negedge clk);
    check_output("rst_ready", {62'd0, b1.req_ready}, 64'd0);
    check_output("rst_resp", {62'd0, b1.resp_valid}, 64'd0);
    check_output("rst_mem_en", {63'd0, b1.mem_en}, 64'd0);
    check_output("rst_rdata", {32'd0, b1.resp_rdata}, 64'd0);
    check_output("rst_ready3", {62'd0, b3.req_ready}, 64'd0);
    cyc();
    rst     = 1'b0;
    preload = 1'b0;

    // Both valid from the first cycle: grants 0,1,0,1 at even cycles, responses at odd cycles.
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      @(negedge clk);
      exp_ready = (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
      exp_resp  = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
      exp_rdata = (c % 2 == 0) ? 32'h0 : ((c % 4 == 1) ? 32'hA5A5A5A5 : 32'h11112222);
      check_output($sformatf("rr_ready_c%0d", c), {62'd0, b1.req_ready}, {62'd0, exp_ready});
      check_output($sformatf("rr_resp_c%0d", c), {62'd0, b1.resp_valid}, {62'd0, exp_resp});
      check_output($sformatf("rr_rdata_c%0d", c), {32'd0, b1.resp_rdata}, {32'd0, exp_rdata});
      check_output($sformatf("rr_mem_en_c%0d", c), {63'd0, b1.mem_en}, {63'd0, (c % 2 == 0)});
    end
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);

    // CPU read of 0x010.
    cyc();
    apply_stimulus(2'b01, 2'b00, 14'h010, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("rd_ready", {62'd0, b1.req_ready}, 64'h1);
    check_output("rd_mem_addr", {50'd0, b1.mem_addr}, 64'h10);
    check_output("rd_mem_we", {60'd0, b1.mem_we}, 64'h0);
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("rd_resp", {62'd0, b1.resp_valid}, 64'h1);
    check_output("rd_rdata", {32'd0, b1.resp_rdata}, 64'hDEADBEEF);
    check_output("rd_wait_mem_en", {63'd0, b1.mem_en}, 64'h0);
    cyc();
    @(negedge clk);
    check_output("rd_after_resp", {62'd0, b1.resp_valid}, 64'h0);
    check_output("rd_after_rdata", {32'd0, b1.resp_rdata}, 64'h0);

    // Loader partial write to 0x020, then CPU read-back.
    cyc();
    apply_stimulus(2'b10, 2'b10, 14'h0, 14'h020, 32'h12345678, 4'b0011);
    @(negedge clk);
    check_output("wr_ready", {62'd0, b1.req_ready}, 64'h2);
    check_output("wr_mem_we", {60'd0, b1.mem_we}, 64'h3);
    check_output("wr_mem_din", {32'd0, b1.mem_din}, 64'h12345678);
    check_output("wr_mem_addr", {50'd0, b1.mem_addr}, 64'h20);
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("wr_resp", {62'd0, b1.resp_valid}, 64'h2);
    check_output("wr_rdata", {32'd0, b1.resp_rdata}, 64'h0);
    cyc();
    apply_stimulus(2'b01, 2'b00, 14'h020, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("rb_ready", {62'd0, b1.req_ready}, 64'h1);
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("rb_resp", {62'd0, b1.resp_valid}, 64'h1);
    check_output("rb_rdata", {32'd0, b1.resp_rdata}, 64'hFFFF5678);

    // Reset right after a CPU accept abandons the read; tie priority returns to the CPU.
    cyc();
    apply_stimulus(2'b01, 2'b00, 14'h010, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("ab_ready", {62'd0, b1.req_ready}, 64'h1);
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    check_output("ab_resp_in_rst", {62'd0, b1.resp_valid}, 64'h0);
    cyc();
    rst = 1'b0;
    apply_stimulus(2'b11, 2'b00, 14'h010, 14'h040, 32'h0, 4'h0);
    @(negedge clk);
    check_output("ab_tie_ready", {62'd0, b1.req_ready}, 64'h1);
    check_output("ab_no_resp", {62'd0, b1.resp_valid}, 64'h0);
    cyc();
    @(negedge clk);
    check_output("ab_resp0", {62'd0, b1.resp_valid}, 64'h1);
    check_output("ab_rdata0", {32'd0, b1.resp_rdata}, 64'hDEADBEEF);
    cyc();
    @(negedge clk);
    check_output("ab_ldr_ready", {62'd0, b1.req_ready}, 64'h2);
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_output("ab_ldr_resp", {62'd0, b1.resp_valid}, 64'h2);
    check_output("ab_ldr_rdata", {32'd0, b1.resp_rdata}, 64'h11112222);

    // Loader alone held valid for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) apply_stimulus(2'b10, 2'b00, 14'h0, 14'h040, 32'h0, 4'h0);
      @(negedge clk);
      exp_ready = (c % 2 == 0) ? 2'b10 : 2'b00;
      exp_resp  = (c % 2 == 1) ? 2'b10 : 2'b00;
      check_output($sformatf("ldr_ready_c%0d", c), {62'd0, b1.req_ready}, {62'd0, exp_ready});
      check_output($sformatf("ldr_resp_c%0d", c), {62'd0, b1.resp_valid}, {62'd0, exp_resp});
      check_output($sformatf("ldr_mem_en_c%0d", c), {63'd0, b1.mem_en}, {63'd0, (c % 2 == 0)});
    end
    cyc();
    apply_stimulus(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 4'h0);

    // Latency 3: CPU wins the tie at t0, responds at t3; loader accepted at t4, responds at t7.
    cyc();
    b3.req_valid = 2'b11;
    b3.req_addr  = {14'h040, 14'h010};
    for (int c = 0; c < 9; c++) begin
      if (c > 0) cyc();
      @(negedge clk);
      exp_ready = (c == 0 || c == 8) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
      exp_resp  = (c == 3) ? 2'b01 : ((c == 7) ? 2'b10 : 2'b00);
      exp_rdata = (c == 3) ? 32'hCAFEF00D : ((c == 7) ? 32'h0BADC0DE : 32'h0);
      check_output($sformatf("l3_ready_c%0d", c), {62'd0, b3.req_ready}, {62'd0, exp_ready});
      check_output($sformatf("l3_resp_c%0d", c), {62'd0, b3.resp_valid}, {62'd0, exp_resp});
      check_output($sformatf("l3_rdata_c%0d", c), {32'd0, b3.resp_rdata}, {32'd0, exp_rdata});
    end
    cyc();
    b3.req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
